// File: rtl/vm2002_pkg.sv
// Shared vm2002 types: coin encoding, coin values and change-dispenser FSM states.
package vm2002_pkg;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'b00,
      COIN_NICKEL  = 2'b01,
      COIN_DIME    = 2'b10,
      COIN_QUARTER = 2'b11
   } coin_t;

   localparam logic [4:0] VAL_NONE    = 5'd0;
   localparam logic [4:0] VAL_NICKEL  = 5'd5;
   localparam logic [4:0] VAL_DIME    = 5'd10;
   localparam logic [4:0] VAL_QUARTER = 5'd25;

   // One-hot change-dispenser states, decoded through the index constants below
   typedef enum logic [3:0] {
      CHG_IDLE    = 4'b0001,
      CHG_SELECT  = 4'b0010,
      CHG_PRESENT = 4'b0100,
      CHG_DONE    = 4'b1000
   } chg_state_t;

   localparam int CHG_IDLE_IDX    = 0;
   localparam int CHG_SELECT_IDX  = 1;
   localparam int CHG_PRESENT_IDX = 2;
   localparam int CHG_DONE_IDX    = 3;

   function automatic logic [4:0] coin_value(input coin_t c);
      logic [4:0] v;
      v = VAL_NONE;
      case (c)
         COIN_NICKEL:  v = VAL_NICKEL;
         COIN_DIME:    v = VAL_DIME;
         COIN_QUARTER: v = VAL_QUARTER;
         default:      v = VAL_NONE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin tube: 4-bit level with saturating refill and single-coin ejection.
module vm2002_coin_tube #(
   parameter int INIT = 0,
   parameter int MAX  = 15
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       add_i,
   input  logic [3:0] add_cnt_i,
   input  logic       dec_i,
   output logic [3:0] level_o,
   output logic       empty_o
);

   logic [3:0] level_q, level_d;
   logic [5:0] sum;

   // Refill and ejection net out in one step, then clamp to tube capacity.
   // An ejection only follows a selection that saw this tube non-empty, so
   // the subtraction never goes below zero.
   always_comb begin
      sum     = {2'b00, level_q} + (add_i ? {2'b00, add_cnt_i} : 6'd0) - (dec_i ? 6'd1 : 6'd0);
      level_d = (sum > 6'(MAX)) ? 4'(MAX) : sum[3:0];
   end

   // Level register, restored to the fill level on reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) level_q <= 4'(INIT);
      else          level_q <= level_d;
   end

   assign level_o = level_q;
   assign empty_o = (level_q == 4'd0);

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Change dispenser: greedy quarter/dime/nickel payout over a valid/ack ejector
// handshake, with per-tube inventory and jam detection on ack timeout.
import vm2002_pkg::*;

module vm2002_change_dispenser #(
   parameter int TUBE_MAX     = 15,
   parameter int NICKEL_INIT  = 10,
   parameter int DIME_INIT    = 10,
   parameter int QUARTER_INIT = 8,
   parameter int ACK_TIMEOUT  = 255
) (
   input  logic        clk_i,
   input  logic        hrst_n_i,
   input  logic        req_i,
   input  logic [15:0] amount_i,
   input  logic        load_i,
   input  logic [1:0]  load_coin_i,
   input  logic [3:0]  load_count_i,
   input  logic        coin_ack_i,
   output logic [1:0]  coin_out_o,
   output logic        coin_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        short_o,
   output logic        jam_o,
   output logic [15:0] remainder_o,
   output logic [2:0]  tube_empty_o
);

   // Timeout counter runs 0..ACK_TIMEOUT-1 while a coin is presented
   localparam int            TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

   chg_state_t      state_q;
   coin_t           coin_q, pick;
   logic [15:0]     rem_q, remainder_q;
   logic [TW-1:0]   to_cnt_q;
   logic            valid_q, done_q, short_q, jam_q;
   logic            ack_take;
   logic [2:0][3:0] tube_lvl;
   logic [2:0]      tube_add, tube_dec, tube_empty;

   assign ack_take = state_q[CHG_PRESENT_IDX] && coin_ack_i;

   // Tubes indexed 0 nickel, 1 dime, 2 quarter (coin_t code minus one)
   for (genvar i = 0; i < 3; i++) begin : g_tube
      localparam int INIT = (i == 0) ? NICKEL_INIT : ((i == 1) ? DIME_INIT : QUARTER_INIT);
      assign tube_add[i] = load_i && (load_coin_i == 2'(i + 1));
      assign tube_dec[i] = ack_take && (coin_q == coin_t'(i + 1));
      vm2002_coin_tube #(.INIT(INIT), .MAX(TUBE_MAX)) u_tube (
         .clk_i     (clk_i),
         .rst_n_i   (hrst_n_i),
         .add_i     (tube_add[i]),
         .add_cnt_i (load_count_i),
         .dec_i     (tube_dec[i]),
         .level_o   (tube_lvl[i]),
         .empty_o   (tube_empty[i])
      );
   end

   // Greedy pick from registered tube levels: largest coin that fits and is stocked
   always_comb begin
      pick = COIN_NONE;
      if (rem_q >= {11'd0, VAL_QUARTER} && tube_lvl[2] != 4'd0)   pick = COIN_QUARTER;
      else if (rem_q >= {11'd0, VAL_DIME} && tube_lvl[1] != 4'd0) pick = COIN_DIME;
      else if (rem_q >= {11'd0, VAL_NICKEL} && tube_lvl[0] != 4'd0) pick = COIN_NICKEL;
   end

   // Payout FSM with registered outputs; results are latched on entry to DONE
   // so remainder/short/jam are already valid in the done cycle
   always_ff @(posedge clk_i or negedge hrst_n_i) begin
      if (!hrst_n_i) begin
         state_q     <= CHG_IDLE;
         rem_q       <= '0;
         coin_q      <= COIN_NONE;
         valid_q     <= 1'b0;
         to_cnt_q    <= '0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         jam_q       <= 1'b0;
         remainder_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (1'b1)
            state_q[CHG_IDLE_IDX]: begin
               if (req_i) begin
                  rem_q       <= amount_i;
                  short_q     <= 1'b0;
                  jam_q       <= 1'b0;
                  remainder_q <= '0;
                  state_q     <= CHG_SELECT;
               end
            end
            state_q[CHG_SELECT_IDX]: begin
               if (pick != COIN_NONE) begin
                  coin_q   <= pick;
                  valid_q  <= 1'b1;
                  to_cnt_q <= '0;
                  state_q  <= CHG_PRESENT;
               end else begin
                  done_q      <= 1'b1;
                  remainder_q <= rem_q;
                  short_q     <= (rem_q != 16'd0);
                  state_q     <= CHG_DONE;
               end
            end
            state_q[CHG_PRESENT_IDX]: begin
               if (coin_ack_i) begin
                  rem_q   <= rem_q - {11'd0, coin_value(coin_q)};
                  coin_q  <= COIN_NONE;
                  valid_q <= 1'b0;
                  state_q <= CHG_SELECT;
               end else if (to_cnt_q == TO_LAST) begin
                  // Ejector never took the coin: abandon it, tube stays untouched
                  coin_q      <= COIN_NONE;
                  valid_q     <= 1'b0;
                  jam_q       <= 1'b1;
                  done_q      <= 1'b1;
                  remainder_q <= rem_q;
                  short_q     <= (rem_q != 16'd0);
                  state_q     <= CHG_DONE;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            state_q[CHG_DONE_IDX]: state_q <= CHG_IDLE;
            default:               state_q <= CHG_IDLE;
         endcase
      end
   end

   assign coin_out_o   = coin_q;
   assign coin_valid_o = valid_q;
   assign busy_o       = ~state_q[CHG_IDLE_IDX];
   assign done_o       = done_q;
   assign short_o      = short_q;
   assign jam_o        = jam_q;
   assign remainder_o  = remainder_q;
   assign tube_empty_o = tube_empty;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed scenarios then randomized payouts,
// checked against a greedy-payout model built from coin values and tube counts.
module tb_vm2002_change_dispenser;

   localparam int TO = 4;

   logic        clk = 1'b0, hrst_n = 1'b0, req = 1'b0, load = 1'b0, coin_ack = 1'b0;
   logic [15:0] amount = '0;
   logic [1:0]  load_coin = '0;
   logic [3:0]  load_count = '0;
   logic [1:0]  coin_out;
   logic        coin_valid, busy, done, sh, jam;
   logic [15:0] remainder;
   logic [2:0]  tube_empty;

   int n_tests = 0, n_fail = 0;
   int mt[3];                       // model tube levels: nickel, dime, quarter
   int coin_val[3] = '{5, 10, 25};
   int dly_q[$];                    // ack delay per presented coin (>= TO means no ack)
   int spur_req = 0, spur_ack = 0;
   int ld_on_ack = 0, ld_coin = 0, ld_cnt = 0;

   vm2002_change_dispenser #(.ACK_TIMEOUT(TO)) dut (
      .clk_i(clk), .hrst_n_i(hrst_n), .req_i(req), .amount_i(amount),
      .load_i(load), .load_coin_i(load_coin), .load_count_i(load_count),
      .coin_ack_i(coin_ack), .coin_out_o(coin_out), .coin_valid_o(coin_valid),
      .busy_o(busy), .done_o(done), .short_o(sh), .jam_o(jam),
      .remainder_o(remainder), .tube_empty_o(tube_empty)
   );

   always #5 clk = ~clk;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_tubes(input string tag);
      check({tag, "_lvl_n"}, dut.tube_lvl[0], mt[0]);
      check({tag, "_lvl_d"}, dut.tube_lvl[1], mt[1]);
      check({tag, "_lvl_q"}, dut.tube_lvl[2], mt[2]);
      check({tag, "_empty"}, tube_empty, {29'd0, mt[2] == 0, mt[1] == 0, mt[0] == 0});
   endtask

   task automatic do_load(input int c, input int cnt);
      @(negedge clk); load = 1'b1; load_coin = 2'(c); load_count = 4'(cnt);
      @(negedge clk); load = 1'b0;
      if (c != 0) mt[c-1] = imin(mt[c-1] + cnt, 15);
   endtask

   // One change request: model the expected payout, drive the handshake, compare.
   task automatic pay(input int amt);
      int t, rem, exp_jam, d, k, vcnt, cyc, got_done;
      int exp_coins[$];
      int obs_coins[$];
      // Model: greedy over stocked coins; each acked coin costs select + (delay+1)
      rem = amt; t = 1; exp_jam = 0;
      for (int n = 0; n < 64; n++) begin
         int c;
         c = -1;
         if (rem >= 25 && mt[2] > 0)      c = 2;
         else if (rem >= 10 && mt[1] > 0) c = 1;
         else if (rem >= 5 && mt[0] > 0)  c = 0;
         if (c < 0) begin t = t + 1; break; end
         exp_coins.push_back(c + 1);
         d = (n < dly_q.size()) ? dly_q[n] : 0;
         if (d >= TO) begin exp_jam = 1; t = t + TO + 1; break; end
         rem = rem - coin_val[c];
         mt[c] = mt[c] - 1;
         t = t + d + 2;
      end
      if (ld_on_ack != 0) mt[ld_coin-1] = imin(mt[ld_coin-1] + ld_cnt, 15);

      @(negedge clk); req = 1'b1; amount = 16'(amt);
      @(negedge clk); req = 1'b0; amount = 16'($urandom);
      cyc = 1; vcnt = 0; k = 0; got_done = 0;
      while (cyc < 400) begin
         coin_ack = 1'b0; load = 1'b0;
         req = (spur_req != 0 && busy && $urandom_range(0, 3) == 0);
         if (done) begin got_done = 1; break; end
         if (coin_valid) begin
            if (vcnt == 0) obs_coins.push_back(int'(coin_out));
            d = (k < dly_q.size()) ? dly_q[k] : 0;
            if (vcnt == d) begin
               coin_ack = 1'b1;
               if (ld_on_ack != 0) begin
                  load = 1'b1; load_coin = 2'(ld_coin); load_count = 4'(ld_cnt);
               end
            end
            vcnt++;
         end else begin
            check("coin_out_none", coin_out, 0);
            if (vcnt != 0) k++;
            vcnt = 0;
            if (spur_ack != 0) coin_ack = 1'($urandom_range(0, 1));
         end
         @(negedge clk); cyc++;
      end
      coin_ack = 1'b0; req = 1'b0; load = 1'b0;

      check("done_seen", got_done, 1);
      check("done_cycle", cyc, t);
      check("n_coins", obs_coins.size(), exp_coins.size());
      for (int i = 0; i < imin(obs_coins.size(), exp_coins.size()); i++)
         check("coin", obs_coins[i], exp_coins[i]);
      check("short", sh, rem != 0);
      check("jam", jam, exp_jam);
      check("remainder", remainder, rem);
      check_tubes("pay");
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("short_held", sh, rem != 0);
      check("rem_held", remainder, rem);
   endtask

   initial begin
      mt = '{10, 10, 8};
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", coin_valid, 0);
      check("rst_busy", busy, 0);
      hrst_n = 1'b1;
      @(negedge clk);
      check("rst_coin", coin_out, 0);
      check("rst_done", done, 0);
      check("rst_short", sh, 0);
      check("rst_jam", jam, 0);
      check("rst_rem", remainder, 0);
      check_tubes("rst");

      // 65 with immediate ack: Q Q D N, tubes to 9/9/6
      dly_q.delete();
      pay(65);
      // Drain quarters, then 30 pays in dimes only
      pay(150);
      pay(30);
      // Drain nickels, take dimes down to 3, restock 4 quarters
      for (int i = 0; i < 9; i++) pay(5);
      pay(30);
      do_load(3, 4);
      // Greedy quarter leaves 5 unpayable with no nickels
      pay(30);
      // Odd residual, then zero amount
      do_load(1, 2);
      pay(7);
      pay(0);
      // Jam on ack timeout: whole amount unpaid, tube unchanged
      dly_q = '{99};
      pay(10);
      // Dime tube to 5, then refill by 15 in the very cycle a dime is acked
      dly_q.delete();
      do_load(2, 2);
      ld_on_ack = 1; ld_coin = 2; ld_cnt = 15;
      pay(10);
      ld_on_ack = 0;
      // NONE refill is a no-op
      do_load(0, 9);
      check_tubes("load_none");

      // Async reset while a coin is presented
      @(negedge clk); req = 1'b1; amount = 16'd25;
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", coin_valid, 1);
      #2 hrst_n = 1'b0;
      #1;
      check("async_rst_valid", coin_valid, 0);
      check("async_rst_busy", busy, 0);
      mt = '{10, 10, 8};
      check_tubes("async_rst");
      @(negedge clk); hrst_n = 1'b1;

      // Randomized payouts with refills, occasional jams and ignored strobes
      spur_req = 1; spur_ack = 1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, 3), $urandom_range(0, 15));
         dly_q.delete();
         for (int j = 0; j < 16; j++)
            dly_q.push_back(($urandom_range(0, 11) == 0) ? TO + $urandom_range(0, 3)
                                                          : $urandom_range(0, 2));
         pay($urandom_range(0, 160));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
